// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter bus shared by uart_tx_arbiter.
// The master modport is the arbiter side: it accepts requester bytes and drives uart_tx.
// The slave modport is the environment side: producers plus the uart_tx transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_parity;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_done;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_parity_type;
  logic                 tx_done;

  modport master (
    input  req_valid, req_data, req_parity, tx_done,
    output req_ready, req_done, tx_start, tx_data, tx_parity_type
  );

  modport slave (
    output req_valid, req_data, req_parity, tx_done,
    input  req_ready, req_done, tx_start, tx_data, tx_parity_type
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers (clk_3125 domain).
// Grants a requester, issues tx_start, waits for the tx_done rising edge, pulses req_done,
// then waits for tx_done to fall before accepting the next request.
// Optional watchdog on the tx_done wait: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 400
) (
  input  logic                       clk_3125,
  input  logic                       rst,
  uart_tx_arbiter_if.master          bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, RECOVER} state_t;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC <= 297) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYC must exceed the 297-cycle frame");
  end

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d, ptr_next;
  logic [IDW-1:0]     grant_d, win;
  logic               found;
  logic               tx_done_q, tx_rise;
  logic [NUM_REQ-1:0] ready_d, done_d;
  logic               start_d, parity_d;
  logic [7:0]         data_d;
  logic [7:0]         data_arr [NUM_REQ];
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0]        wdog_q, wdog_d;
  logic               tmo_d;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[8*g +: 8];
  end

  assign tx_rise  = bus.tx_done & ~tx_done_q;
  assign ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy     = (state_q != IDLE);

  // Winner search: first pending requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Next-state and next registered-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_id;
    start_d  = 1'b0;
    ready_d  = '0;
    done_d   = '0;
    data_d   = bus.tx_data;
    parity_d = bus.tx_parity_type;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wdog_d   = wdog_q;
    tmo_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          start_d      = 1'b1;
          ready_d[win] = 1'b1;
          data_d       = data_arr[win];
          parity_d     = bus.req_parity[win];
          grant_d      = win;
          state_d      = WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wdog_d       = '0;
`endif
        end
      end
      WAIT_DONE: begin
        // A tx_done edge coinciding with watchdog expiry is treated as success.
        if (tx_rise) begin
          done_d[grant_id] = 1'b1;
          ptr_d            = ptr_next;
          state_d          = RECOVER;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wdog_q == 16'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          ptr_d   = ptr_next;
          state_d = RECOVER;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      RECOVER: begin
        if (!bus.tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; tx_done_q resets high so a stale tx_done cannot look like an edge.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state_q            <= IDLE;
      ptr_q              <= '0;
      grant_id           <= '0;
      tx_done_q          <= 1'b1;
      bus.tx_start       <= 1'b0;
      bus.tx_data        <= 8'h00;
      bus.tx_parity_type <= 1'b0;
      bus.req_ready      <= '0;
      bus.req_done       <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wdog_q             <= '0;
      timeout_err        <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      grant_id           <= grant_d;
      tx_done_q          <= bus.tx_done;
      bus.tx_start       <= start_d;
      bus.tx_data        <= data_d;
      bus.tx_parity_type <= parity_d;
      bus.req_ready      <= ready_d;
      bus.req_done       <= done_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wdog_q             <= wdog_d;
      timeout_err        <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4): grant table plus hand sequences for
// back-to-back frames, long tx_done, reset mid-frame and (with UART_TX_ARB_TIMEOUT_EN) watchdog.
module tb_uart_tx_arbiter;
  logic       clk_3125;
  logic       rst;
  logic       busy;
  logic [1:0] grant_id;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic       timeout_err;
`endif

  int unsigned nerr   = 0;
  int unsigned nchk   = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(400)) dut (
    .clk_3125    (clk_3125),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk_3125 = 1'b0;
  always #5 clk_3125 = ~clk_3125;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  par;
    int unsigned wait_cyc;
    logic [1:0]  exp_w;
    logic [7:0]  exp_data;
    logic        exp_par;
  } vec_t;

  vec_t vecs [9];

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_3125);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Checks the cycle after the grant edge, then the return of tx_start/req_ready to 0.
  task automatic check_grant(input string name, input logic [1:0] w, input logic [7:0] d,
                             input logic p);
    chk({name, ".tx_start"}, 32'(bus.tx_start), 32'd1);
    chk({name, ".req_ready"}, 32'(bus.req_ready), 32'(4'b0001 << w));
    chk({name, ".tx_data"}, 32'(bus.tx_data), 32'(d));
    chk({name, ".tx_parity"}, 32'(bus.tx_parity_type), 32'(p));
    chk({name, ".grant_id"}, 32'(grant_id), 32'(w));
    chk({name, ".busy"}, 32'(busy), 32'd1);
  endtask

  // Waits, pulses tx_done for one cycle, checks the single req_done pulse and return to IDLE.
  task automatic finish_frame(input string name, input int unsigned wait_cyc,
                              input logic [1:0] w);
    repeat (wait_cyc) tick();
    bus.tx_done = 1'b1;
    tick();
    chk({name, ".req_done"}, 32'(bus.req_done), 32'(4'b0001 << w));
    bus.tx_done = 1'b0;
    tick();
    chk({name, ".req_done_clr"}, 32'(bus.req_done), 32'd0);
    chk({name, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned gap;
    int unsigned ndone;
    logic [1:0]  ew;

    // Pointer evolution from reset: 0 ->1 ->3 ->1 ->2 ->1 ->2 ->0 ->0 ->1
    vecs[0] = '{4'b0001, 32'h000000A5, 4'b0000, 294, 2'd0, 8'hA5, 1'b0};
    vecs[1] = '{4'b0101, 32'h44332211, 4'b0100,  10, 2'd2, 8'h33, 1'b1};
    vecs[2] = '{4'b0011, 32'h44332211, 4'b0010,  10, 2'd0, 8'h11, 1'b0};
    vecs[3] = '{4'b0011, 32'h44332211, 4'b0010,  10, 2'd1, 8'h22, 1'b1};
    vecs[4] = '{4'b0011, 32'h5A5A9C0F, 4'b0000,   7, 2'd0, 8'h0F, 1'b0};
    vecs[5] = '{4'b0011, 32'h5A5A9C0F, 4'b0000,   7, 2'd1, 8'h9C, 1'b0};
    vecs[6] = '{4'b1000, 32'hC3000000, 4'b1000,   5, 2'd3, 8'hC3, 1'b1};
    vecs[7] = '{4'b1000, 32'h7E000000, 4'b0000,   5, 2'd3, 8'h7E, 1'b0};
    vecs[8] = '{4'b1111, 32'h44332211, 4'b1010,   5, 2'd0, 8'h11, 1'b0};

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_parity = '0;
    bus.tx_done    = 1'b0;
    repeat (3) tick();
    chk("rst.tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst.tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst.tx_parity", 32'(bus.tx_parity_type), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.req_done", 32'(bus.req_done), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.grant_id", 32'(grant_id), 32'd0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("rst.timeout_err", 32'(timeout_err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Grant table: one request pattern per row, frame completed before the next row.
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d.pre_idle", i), 32'(busy), 32'd0);
      bus.req_valid  = vecs[i].valid;
      bus.req_data   = vecs[i].data;
      bus.req_parity = vecs[i].par;
      tick();
      check_grant($sformatf("v%0d", i), vecs[i].exp_w, vecs[i].exp_data, vecs[i].exp_par);
      bus.req_valid = '0;
      tick();
      chk($sformatf("v%0d.start_clr", i), 32'(bus.tx_start), 32'd0);
      chk($sformatf("v%0d.ready_clr", i), 32'(bus.req_ready), 32'd0);
      finish_frame($sformatf("v%0d", i), vecs[i].wait_cyc, vecs[i].exp_w);
    end

    // Reset 100 cycles into WAIT_DONE (pointer is 1, so requester 2 wins).
    bus.req_valid = 4'b0100;
    tick();
    check_grant("rmid", 2'd2, 8'h33, 1'b0);
    bus.req_valid = '0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid.tx_start", 32'(bus.tx_start), 32'd0);
    chk("rmid.tx_data", 32'(bus.tx_data), 32'd0);
    chk("rmid.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.grant_id", 32'(grant_id), 32'd0);
    tick();
    bus.tx_done = 1'b1;
    ndone = 0;
    repeat (2) begin
      tick();
      if (bus.req_done != 4'b0000) ndone++;
    end
    bus.tx_done = 1'b0;
    repeat (2) begin
      tick();
      if (bus.req_done != 4'b0000) ndone++;
    end
    chk("rmid.no_done", ndone, 0);
    chk("rmid.still_idle", 32'(busy), 32'd0);

    // Back-to-back with all four pending: pointer was reset to 0, order 11,22,33,44,11.
    bus.req_valid  = 4'b1111;
    bus.req_data   = 32'h44332211;
    bus.req_parity = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      ew = 2'(k % 4);
      check_grant($sformatf("b2b%0d", k), ew, 8'(8'h11 * (ew + 1)), 1'b0);
      repeat (20) tick();
      if (k == 4) bus.req_valid = '0;
      bus.tx_done = 1'b1;
      tick();
      chk($sformatf("b2b%0d.req_done", k), 32'(bus.req_done), 32'(4'b0001 << ew));
      bus.tx_done = 1'b0;
      if (k < 4) begin
        gap = 0;
        do begin
          tick();
          gap++;
        end while (!bus.tx_start && gap < 10);
        chk($sformatf("b2b%0d.gap", k), gap, 2);
      end else begin
        tick();
        chk("b2b.end_idle", 32'(busy), 32'd0);
      end
    end

    // tx_done held high for 3 cycles: one req_done, no tx_start until tx_done falls.
    bus.req_valid = 4'b0010;
    tick();
    check_grant("hold", 2'd1, 8'h22, 1'b0);
    bus.req_valid = '0;
    repeat (10) tick();
    bus.tx_done = 1'b1;
    tick();
    chk("hold.req_done", 32'(bus.req_done), 32'b0010);
    ndone = 1;
    bus.req_valid = 4'b0001;
    repeat (2) begin
      tick();
      if (bus.req_done != 4'b0000) ndone++;
      chk("hold.no_start", 32'(bus.tx_start), 32'd0);
      chk("hold.recover_busy", 32'(busy), 32'd1);
    end
    bus.tx_done = 1'b0;
    tick();
    if (bus.req_done != 4'b0000) ndone++;
    chk("hold.no_start_exit", 32'(bus.tx_start), 32'd0);
    chk("hold.done_count", ndone, 1);
    tick();
    check_grant("hold_next", 2'd0, 8'h11, 1'b0);
    bus.req_valid = '0;
    finish_frame("hold_next", 10, 2'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog: tx_done never rises; timeout 400 cycles after tx_start, pointer moves past 2.
    bus.req_valid = 4'b0101;
    tick();
    check_grant("tmo", 2'd2, 8'h33, 1'b0);
    bus.req_valid = 4'b0001;
    gap   = 0;
    ndone = 0;
    while (!timeout_err && gap < 500) begin
      tick();
      gap++;
      if (bus.req_done != 4'b0000) ndone++;
    end
    chk("tmo.latency", gap, 400);
    chk("tmo.no_done", ndone, 0);
    tick();
    chk("tmo.pulse_clr", 32'(timeout_err), 32'd0);
    tick();
    check_grant("tmo_next", 2'd0, 8'h11, 1'b0);
    bus.req_valid = '0;
    finish_frame("tmo_next", 10, 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1);
  end
endmodule
